// File: rtl/bitonic_sort_unit_pkg.sv
// rtl/bitonic_sort_unit_pkg.sv - shared constants and network helpers for the bitonic sorter
package bitonic_sort_unit_pkg;

  localparam int unsigned DEFAULT_WAY_WIDTH = 4;
  localparam int unsigned DEFAULT_NUM_WAY   = 16;

  function automatic int unsigned log2_fn(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Number of merge phases (L).
  function automatic int unsigned num_phases(input int unsigned n);
    return log2_fn(n);
  endfunction

  // Number of compare-exchange columns, one pipeline register each (S).
  function automatic int unsigned num_columns(input int unsigned n);
    int unsigned l;
    l = log2_fn(n);
    return (l * (l + 1)) / 2;
  endfunction

  // 1 = ascending (lower way receives the min). Phase p merges blocks of 2^p ways; the
  // block's bit p selects direction, so the last phase is always ascending.
  function automatic logic ascending_dir(input int unsigned phase, input int unsigned step,
                                         input int unsigned way);
    if (step >= phase) return 1'b1;
    return ((way >> phase) & 32'd1) == 32'd0;
  endfunction

endpackage

// File: rtl/bitonic_compare_exchange.sv
// rtl/bitonic_compare_exchange.sv - combinational compare-exchange cell of the bitonic network
module bitonic_compare_exchange #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         asc_i,
  output logic [W-1:0] lo_o,
  output logic [W-1:0] hi_o
);

  // Equal keys never swap.
  logic swap;
  assign swap = asc_i ? (a_i > b_i) : (a_i < b_i);

  assign lo_o = swap ? b_i : a_i;
  assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/bitonic_sort_unit.sv
// rtl/bitonic_sort_unit.sv - fully pipelined ascending bitonic sorter, one register per column
module bitonic_sort_unit
  import bitonic_sort_unit_pkg::*;
#(
  parameter int unsigned SINGLE_WAY_WIDTH_IN_BITS = DEFAULT_WAY_WIDTH,
  parameter int unsigned NUM_WAY                  = DEFAULT_NUM_WAY
) (
  input  logic                                          clk_in,
  input  logic                                          reset_in,
  input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]   pre_sort_flatted_in,
  output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]   post_sort_flatted_out
);

  localparam int unsigned W  = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int unsigned N  = NUM_WAY;
  localparam int unsigned NW = W * N;
  localparam int unsigned L  = num_phases(N);
  localparam int unsigned S  = num_columns(N);

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_num_way
    $error("bitonic_sort_unit: NUM_WAY must be a power of 2 and at least 2");
  end

  // Column c's result lives in slice [c*NW +: NW] of the flattened pipeline.
  logic [S*NW-1:0] pipe_d;
  logic [S*NW-1:0] pipe_q;

  for (genvar p = 1; p <= L; p++) begin : g_phase
    for (genvar j = 0; j < p; j++) begin : g_step
      localparam int unsigned COL  = (p * (p - 1)) / 2 + j;
      localparam int unsigned DIST = 1 << (p - 1 - j);

      logic [NW-1:0] col_in;
      if (COL == 0) begin : g_first
        assign col_in = pre_sort_flatted_in;
      end else begin : g_next
        assign col_in = pipe_q[(COL-1)*NW +: NW];
      end

      for (genvar q = 0; q < N / 2; q++) begin : g_pair
        localparam int unsigned LO = (q / DIST) * 2 * DIST + (q % DIST);
        localparam int unsigned HI = LO + DIST;

        bitonic_compare_exchange #(
          .W(W)
        ) u_cx (
          .a_i  (col_in[LO*W +: W]),
          .b_i  (col_in[HI*W +: W]),
          .asc_i(ascending_dir(p, j, LO)),
          .lo_o (pipe_d[COL*NW + LO*W +: W]),
          .hi_o (pipe_d[COL*NW + HI*W +: W])
        );
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign post_sort_flatted_out = pipe_q[(S-1)*NW +: NW];

endmodule

// File: tb/tb_bitonic_sort_unit.sv
// tb/tb_bitonic_sort_unit.sv - scoreboard bench for bitonic_sort_unit at N=16, W=4
module tb_bitonic_sort_unit;

  localparam int W  = 4;
  localparam int N  = 16;
  localparam int S  = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   din = '0;
  logic [63:0]   dout;

  int n_vec  = 0;
  int n_miss = 0;

  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  bitonic_sort_unit #(
    .SINGLE_WAY_WIDTH_IN_BITS(W),
    .NUM_WAY(N)
  ) dut (
    .clk_in               (clk),
    .reset_in             (rst_n),
    .pre_sort_flatted_in  (din),
    .post_sort_flatted_out(dout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_sort(input logic [63:0] v);
    logic [3:0] k [16];
    logic [3:0] t;
    logic [63:0] r;
    for (int i = 0; i < N; i++) k[i] = v[i*W +: W];
    for (int i = 0; i < N - 1; i++)
      for (int m = 0; m < N - 1 - i; m++)
        if (k[m] > k[m+1]) begin
          t = k[m];
          k[m] = k[m+1];
          k[m+1] = t;
        end
    for (int i = 0; i < N; i++) r[i*W +: W] = k[i];
    return r;
  endfunction

  function automatic logic [63:0] ordered(input logic [63:0] v);
    for (int i = 1; i < N; i++)
      if (v[i*W +: W] < v[(i-1)*W +: W]) return 64'd0;
    return 64'd1;
  endfunction

  // One clock: drive at the falling edge, model the edge, sample at the next falling edge.
  task automatic step(input string tag, input logic [63:0] vin, input logic [63:0] vexp,
                      input logic rst);
    din   = vin;
    rst_n = ~rst;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      repeat (S - 1) exp_q.push_back(64'd0);
      @(negedge clk);
      check("reset_zero", dout, 64'd0);
    end else begin
      exp_q.push_back(vexp);
      @(negedge clk);
      check(tag, dout, exp_q.pop_front());
      check("ascending", ordered(dout), 64'd1);
    end
  endtask

  task automatic rand_vec(input string tag);
    logic [63:0] v;
    v = {$urandom, $urandom};
    step(tag, v, ref_sort(v), 1'b0);
  endtask

  initial begin
    @(negedge clk);
    repeat (3) step("reset", 64'd0, 64'd0, 1'b1);

    repeat (S + 500) step("reverse_hold", 64'h0123456789abcdef, 64'hfedcba9876543210, 1'b0);

    step("dup_reverse", 64'h0022446688bbddff, 64'hffddbb8866442200, 1'b0);
    step("rand_dup",    64'h87b4acfa03f54892, 64'hffcbaa9887544320, 1'b0);
    step("reverse",     64'h0123456789abcdef, 64'hfedcba9876543210, 1'b0);
    step("sorted",      64'hfedcba9876543210, 64'hfedcba9876543210, 1'b0);
    step("all_equal",   64'h5555555555555555, 64'h5555555555555555, 1'b0);

    repeat (100) rand_vec("random");

    repeat (5) rand_vec("pre_reset");
    repeat (2) step("reset", 64'h87b4acfa03f54892, 64'd0, 1'b1);
    step("after_release", 64'h87b4acfa03f54892, 64'hffcbaa9887544320, 1'b0);
    repeat (30) rand_vec("post_reset");

    repeat (S) step("drain", 64'h0123456789abcdef, 64'hfedcba9876543210, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
